// File: rtl/cv32e40x_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters and a one-entry-per-cycle flush walk.
// Optional hit/misprediction statistics are enabled with `define CV32E40X_BP_STATS_EN.
module cv32e40x_branch_predictor #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_if_i,
  output logic        hit_o,
  output logic        prediction_o,
  output logic [31:0] target_o,
  input  logic [2:0]  cmd_i,
  input  logic [31:0] upd_pc_i,
  input  logic [31:0] upd_target_i,
  output logic        busy_o,
  output logic [15:0] lookup_cnt_o,
  output logic [15:0] mispred_cnt_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  localparam logic [2:0] CMD_TAKEN     = 3'd1;
  localparam logic [2:0] CMD_NOT_TAKEN = 3'd2;
  localparam logic [2:0] CMD_ALLOCATE  = 3'd3;
  localparam logic [2:0] CMD_FLUSH     = 3'd4;

  typedef enum logic [0:0] {
    IDLE_S  = 1'b0,
    FLUSH_S = 1'b1
  } state_e;

  state_e           state_r, state_s;
  logic [IDX_W-1:0] flush_idx_r, flush_idx_s;

  logic [ENTRIES-1:0] valid_r;
  logic [TAG_W-1:0]   tag_r    [ENTRIES];
  logic [31:0]        target_r [ENTRIES];
  logic [1:0]         cnt_r    [ENTRIES];

  logic [IDX_W-1:0] lk_idx_s, up_idx_s;
  logic [TAG_W-1:0] lk_tag_s, up_tag_s;
  logic             busy_s, up_hit_s;
  logic             do_inc_s, do_dec_s, do_alloc_s, flush_clr_s;
  logic             unused_s;

  assign lk_idx_s = pc_if_i[IDX_W+1:2];
  assign lk_tag_s = pc_if_i[31:IDX_W+2];
  assign up_idx_s = upd_pc_i[IDX_W+1:2];
  assign up_tag_s = upd_pc_i[31:IDX_W+2];
  assign unused_s = ^{pc_if_i[1:0], upd_pc_i[1:0]};

  assign busy_s   = (state_r == FLUSH_S);
  assign busy_o   = busy_s;
  assign up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);

  // Lookup reads registered state only, so same-cycle updates are not visible.
  always_comb begin
    hit_o        = 1'b0;
    prediction_o = 1'b0;
    target_o     = 32'h0000_0000;
    if (!busy_s && valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s)) begin
      hit_o        = 1'b1;
      prediction_o = cnt_r[lk_idx_s][1];
      target_o     = target_r[lk_idx_s];
    end else begin
      hit_o        = 1'b0;
    end
  end

  // Next-state and command decode; commands are dropped while the walk runs.
  always_comb begin
    state_s     = state_r;
    flush_idx_s = flush_idx_r;
    do_inc_s    = 1'b0;
    do_dec_s    = 1'b0;
    do_alloc_s  = 1'b0;
    flush_clr_s = 1'b0;
    case (state_r)
      IDLE_S: begin
        case (cmd_i)
          CMD_TAKEN:     do_inc_s   = up_hit_s;
          CMD_NOT_TAKEN: do_dec_s   = up_hit_s;
          CMD_ALLOCATE:  do_alloc_s = 1'b1;
          CMD_FLUSH: begin
            state_s     = FLUSH_S;
            flush_idx_s = '0;
          end
          default: ;
        endcase
      end
      FLUSH_S: begin
        flush_clr_s = 1'b1;
        flush_idx_s = flush_idx_r + IDX_W'(1);
        if (flush_idx_r == LAST_IDX) begin
          state_s = IDLE_S;
        end else begin
          state_s = FLUSH_S;
        end
      end
      default: begin
        state_s     = IDLE_S;
        flush_idx_s = '0;
      end
    endcase
  end

  // FSM state and flush walk index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE_S;
      flush_idx_r <= '0;
    end else begin
      state_r     <= state_s;
      flush_idx_r <= flush_idx_s;
    end
  end

  // Valid bits and direction counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_r[i] <= 2'b01;
      end
    end else if (flush_clr_s) begin
      valid_r[flush_idx_r] <= 1'b0;
    end else if (do_alloc_s) begin
      valid_r[up_idx_s] <= 1'b1;
      cnt_r[up_idx_s]   <= 2'b10;
    end else if (do_inc_s && (cnt_r[up_idx_s] != 2'b11)) begin
      cnt_r[up_idx_s] <= cnt_r[up_idx_s] + 2'd1;
    end else if (do_dec_s && (cnt_r[up_idx_s] != 2'b00)) begin
      cnt_r[up_idx_s] <= cnt_r[up_idx_s] - 2'd1;
    end
  end

  // Tag and target payload; harmless to leave unreset since valid guards it.
  always_ff @(posedge clk) begin
    if (do_alloc_s) begin
      tag_r[up_idx_s]    <= up_tag_s;
      target_r[up_idx_s] <= upd_target_i;
    end
  end

`ifdef CV32E40X_BP_STATS_EN
  logic [15:0] lookup_cnt_r, mispred_cnt_r;
  logic        mispred_s;

  assign mispred_s = (do_inc_s && !cnt_r[up_idx_s][1]) || (do_dec_s && cnt_r[up_idx_s][1]);

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_cnt_r  <= 16'h0000;
      mispred_cnt_r <= 16'h0000;
    end else begin
      if (hit_o && (lookup_cnt_r != 16'hFFFF)) begin
        lookup_cnt_r <= lookup_cnt_r + 16'd1;
      end
      if (mispred_s && (mispred_cnt_r != 16'hFFFF)) begin
        mispred_cnt_r <= mispred_cnt_r + 16'd1;
      end
    end
  end

  assign lookup_cnt_o  = lookup_cnt_r;
  assign mispred_cnt_o = mispred_cnt_r;
`else
  assign lookup_cnt_o  = 16'h0000;
  assign mispred_cnt_o = 16'h0000;
`endif

endmodule

// File: doc/cv32e40x_branch_predictor.md
CV32E40X_BRANCH_PREDICTOR -- requirements
Module: cv32e40x_branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of direct-mapped BTB entries; SHALL be a power of two in 4..64; IDX_W = log2(ENTRIES).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pc_if_i  input  32  IF-stage fetch PC to look up.
REQ-005 hit_o  output  1  lookup PC matches a valid entry; drives the controller hit_i.
REQ-006 prediction_o  output  1  predicted taken; drives the controller prediction_i.
REQ-007 target_o  output  32  predicted branch target.
REQ-008 cmd_i  input  3  update command from the controller cache_operatoin_o: 0 NOP, 1 TAKEN, 2 NOT_TAKEN, 3 ALLOCATE, 4 FLUSH, 5-7 treated as NOP.
REQ-009 upd_pc_i  input  32  PC of the resolved branch (EX stage).
REQ-010 upd_target_i  input  32  resolved target for ALLOCATE.
REQ-011 busy_o  output  1  flush walk in progress.
REQ-012 lookup_cnt_o  output  16  statistics: number of lookups that hit.
REQ-013 mispred_cnt_o  output  16  statistics: number of mispredictions.

Function
REQ-014 Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; each entry holds valid, tag, 32-bit target and a 2-bit counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-015 Lookup SHALL be combinational from registered state: hit_o = valid & tag match; prediction_o = hit_o & counter[1]; target_o = stored target when hit_o, else 0.
REQ-016 TAKEN on a hit SHALL increment the counter, saturating at 11; NOT_TAKEN on a hit SHALL decrement it, saturating at 00; both SHALL be ignored on a miss.
REQ-017 ALLOCATE SHALL write valid=1, tag, upd_target_i and counter=10, overwriting any existing entry at that index.
REQ-018 Updates SHALL take effect on the next clock edge; a same-cycle lookup of the same index SHALL return the pre-update contents (no bypass).
REQ-019 FSM states: IDLE and FLUSH. FLUSH in IDLE SHALL enter FLUSH, set busy_o, and clear valid of entry 0, 1, ... one per cycle; after ENTRIES cycles it SHALL return to IDLE with busy_o low.
REQ-020 While busy_o is high, hit_o and prediction_o SHALL be 0, and all commands, including a further FLUSH, SHALL be ignored.
REQ-021 The flush index counter SHALL wrap to 0 on completion.

Reset
REQ-022 With rst high at a clock edge:
- all valid bits clear
- counters set to 01
- FSM in IDLE with busy_o = 0
- flush index = 0
- statistics counters = 0
REQ-023 Reset SHALL override any command, and reset asserted mid-flush SHALL abort the walk immediately.
REQ-024 Targets and tags need no reset.
REQ-025 Out of reset, hit_o = 0, prediction_o = 0 and target_o = 0.

Configuration
REQ-026 Macro CV32E40X_BP_STATS_EN.
- Defined: lookup_cnt_o SHALL increment on each cycle with hit_o = 1.
- Defined: mispred_cnt_o SHALL increment on TAKEN or NOT_TAKEN to a hit entry whose counter[1] disagrees with the command.
- Defined: both counters SHALL saturate at 0xFFFF and clear only on reset.
- Not defined: both outputs SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-027 Directed scenario: rst, then pc_if_i=0x0000_0100 -> hit_o=0, prediction_o=0, target_o=0.
REQ-028 Directed scenario: ALLOCATE upd_pc_i=0x100, upd_target_i=0x200; next cycle pc_if_i=0x100 -> hit_o=1, prediction_o=1, target_o=0x200; pc_if_i=0x140 (same index, different tag) -> hit_o=0.
REQ-029 Directed scenario: after allocate, NOT_TAKEN x2 at 0x100 -> prediction_o=0 (counter 00); a third NOT_TAKEN -> stays 00; TAKEN x3 -> counter 11, prediction_o=1.
REQ-030 Directed scenario: FLUSH with ENTRIES=16 -> busy_o high for exactly 16 cycles; ALLOCATE during the walk is ignored; afterwards every PC misses.
REQ-031 Directed scenario: same-cycle ALLOCATE and lookup at 0x100 -> hit_o=0 in that cycle, 1 in the next; rst during the 5th flush cycle -> busy_o=0 in the next cycle.
REQ-032 Directed scenario: with CV32E40X_BP_STATS_EN, 3 hitting lookups plus one NOT_TAKEN on counter 10 -> lookup_cnt_o=3, mispred_cnt_o=1; without the macro, both outputs stay 0.
